// File: rtl/pipe_hazard_ctrl.sv
// Hazard/flush sequencer for the 3-stage RNBIP-2 pipeline: memory wait > taken transfer > RAW.
// Optional HAZ_PERF_EN adds saturating stall/flush performance counters with a clear input.
module pipe_hazard_ctrl #(
  parameter int FLUSH_CYCLES = 2,
  parameter int RAW_CYCLES   = 1,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [7:0]       ex_opcode,
  input  logic             ex_flag,
  input  logic             ex_we,
  input  logic [2:0]       ex_waddr,
  input  logic             id_rvalid,
  input  logic [2:0]       id_raddr,
  input  logic             mem_busy,
`ifdef HAZ_PERF_EN
  input  logic             perf_clr,
  output logic [CNT_W-1:0] perf_stall,
  output logic [CNT_W-1:0] perf_flush,
`endif
  output logic             stall_pc,
  output logic             stall_s1,
  output logic             stall_s2,
  output logic             bubble_s3,
  output logic             kill_s1,
  output logic             kill_s2,
  output logic [1:0]       state,
  output logic             busy
);

  typedef enum logic [1:0] {
    S_RUN   = 2'b00,
    S_MEMW  = 2'b01,
    S_FLUSH = 2'b10,
    S_RAW   = 2'b11
  } state_e;

  localparam logic [1:0] FLUSH_INIT = 2'(FLUSH_CYCLES - 1);
  localparam logic [1:0] RAW_INIT   = 2'(RAW_CYCLES - 1);

  generate
    if (FLUSH_CYCLES < 1 || FLUSH_CYCLES > 3 || RAW_CYCLES < 1 || RAW_CYCLES > 3 || CNT_W < 1)
    begin : g_bad_param
      $error("pipe_hazard_ctrl: illegal parameter setting");
    end
  endgenerate

  state_e     r_state, w_nstate;
  logic [1:0] r_cnt, w_ncnt;

  logic w_tt, w_uncond, w_cond, w_raw;
  logic w_hold, w_rawstall, w_kill;

  // Taken-transfer decode on the execute opcode
  always_comb begin
    w_uncond = (ex_opcode[7:3] == 5'b0000_0) && (ex_opcode[2:0] >= 3'd3);
    w_cond   = 1'b0;
    case (ex_opcode[7:3])
      5'b0000_1, 5'b0010_1, 5'b0011_0, 5'b0011_1, 5'b0100_1: w_cond = ex_flag;
      default:                                                w_cond = 1'b0;
    endcase
    w_tt = w_uncond | w_cond;
  end

  assign w_raw = id_rvalid & ex_we & (id_raddr == ex_waddr);

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_RUN;
      r_cnt   <= 2'd0;
    end else begin
      r_state <= w_nstate;
      r_cnt   <= w_ncnt;
    end
  end

  // Next-state logic; a mem_busy cycle in FLUSH/RAW freezes the count
  always_comb begin
    w_nstate = r_state;
    w_ncnt   = r_cnt;
    if (!en) begin
      w_nstate = S_RUN;
      w_ncnt   = 2'd0;
    end else begin
      case (r_state)
        S_RUN: begin
          if (mem_busy) begin
            w_nstate = S_MEMW;
          end else if (w_tt) begin
            w_ncnt   = FLUSH_INIT;
            w_nstate = (FLUSH_INIT != 2'd0) ? S_FLUSH : S_RUN;
          end else if (w_raw) begin
            w_ncnt   = RAW_INIT;
            w_nstate = (RAW_INIT != 2'd0) ? S_RAW : S_RUN;
          end
        end
        S_MEMW: begin
          if (!mem_busy) w_nstate = S_RUN;
        end
        S_FLUSH, S_RAW: begin
          if (!mem_busy) begin
            if (r_cnt <= 2'd1) begin
              w_nstate = S_RUN;
              w_ncnt   = 2'd0;
            end else begin
              w_ncnt = r_cnt - 2'd1;
            end
          end
        end
        default: begin
          w_nstate = S_RUN;
          w_ncnt   = 2'd0;
        end
      endcase
    end
  end

  // Output logic: combinational from state and live inputs
  always_comb begin
    w_hold     = 1'b0;
    w_rawstall = 1'b0;
    w_kill     = 1'b0;
    if (en) begin
      case (r_state)
        S_RUN: begin
          if (mem_busy)   w_hold     = 1'b1;
          else if (w_tt)  w_kill     = 1'b1;
          else if (w_raw) w_rawstall = 1'b1;
        end
        S_MEMW:  w_hold = mem_busy;
        S_FLUSH: begin
          w_kill = 1'b1;
          w_hold = mem_busy;
        end
        S_RAW: begin
          w_rawstall = 1'b1;
          w_hold     = mem_busy;
        end
        default: ;
      endcase
    end
  end

  // Kill and stall may both be raised on a register; the consumer lets kill win
  assign stall_pc  = w_hold | w_rawstall;
  assign stall_s1  = w_hold | w_rawstall;
  assign stall_s2  = w_hold;
  assign bubble_s3 = w_hold | w_rawstall;
  assign kill_s1   = w_kill;
  assign kill_s2   = w_kill;
  assign state     = r_state;
  assign busy      = (r_state != S_RUN);

`ifdef HAZ_PERF_EN
  logic [CNT_W-1:0] r_perf_stall, r_perf_flush;
  logic             w_tt_acc;

  assign w_tt_acc = en & (r_state == S_RUN) & ~mem_busy & w_tt;

  always_ff @(posedge clk) begin
    if (!rst_n || perf_clr) begin
      r_perf_stall <= '0;
      r_perf_flush <= '0;
    end else begin
      if (stall_pc && (r_perf_stall != {CNT_W{1'b1}})) r_perf_stall <= r_perf_stall + 1'b1;
      if (w_tt_acc && (r_perf_flush != {CNT_W{1'b1}})) r_perf_flush <= r_perf_flush + 1'b1;
    end
  end

  assign perf_stall = r_perf_stall;
  assign perf_flush = r_perf_flush;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl (FLUSH_CYCLES=2, RAW_CYCLES=1; CNT_W=2 for saturation).
module tb_pipe_hazard_ctrl;
  localparam int CW = 2;

  logic clk = 1'b0;
  logic rst_n, en, ex_flag, ex_we, id_rvalid, mem_busy;
  logic [7:0] ex_opcode;
  logic [2:0] ex_waddr, id_raddr;
  logic stall_pc, stall_s1, stall_s2, bubble_s3, kill_s1, kill_s2, busy;
  logic [1:0] state;
`ifdef HAZ_PERF_EN
  logic perf_clr;
  logic [CW-1:0] perf_stall, perf_flush;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.FLUSH_CYCLES(2), .RAW_CYCLES(1), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .en(en),
    .ex_opcode(ex_opcode), .ex_flag(ex_flag), .ex_we(ex_we), .ex_waddr(ex_waddr),
    .id_rvalid(id_rvalid), .id_raddr(id_raddr), .mem_busy(mem_busy),
`ifdef HAZ_PERF_EN
    .perf_clr(perf_clr), .perf_stall(perf_stall), .perf_flush(perf_flush),
`endif
    .stall_pc(stall_pc), .stall_s1(stall_s1), .stall_s2(stall_s2), .bubble_s3(bubble_s3),
    .kill_s1(kill_s1), .kill_s2(kill_s2), .state(state), .busy(busy)
  );

  // ctl = {stall_pc, stall_s1, stall_s2, bubble_s3, kill_s1, kill_s2}
  localparam logic [5:0] C_NONE = 6'b000000;
  localparam logic [5:0] C_KILL = 6'b000011;
  localparam logic [5:0] C_RAW  = 6'b110100;
  localparam logic [5:0] C_HOLD = 6'b111100;
  localparam logic [5:0] C_HK   = 6'b111111;

  task automatic check(input string tag, input logic [5:0] ctl, input logic [1:0] st);
    logic [8:0] obs, exp;
    #2;
    obs = {stall_pc, stall_s1, stall_s2, bubble_s3, kill_s1, kill_s2, state, busy};
    exp = {ctl, st, (st != 2'b00)};
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%b required=%b", tag, obs, exp);
    end
  endtask

`ifdef HAZ_PERF_EN
  task automatic check_perf(input string tag, input logic [CW-1:0] es, input logic [CW-1:0] ef);
    n_tests++;
    assert ({perf_stall, perf_flush} === {es, ef}) else begin
      n_fail++;
      $error("FAIL %s observed=%0d/%0d required=%0d/%0d", tag, perf_stall, perf_flush, es, ef);
    end
  endtask
`endif

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    en = 1'b1; ex_opcode = 8'h00; ex_flag = 1'b0; ex_we = 1'b0; ex_waddr = 3'd0;
    id_rvalid = 1'b0; id_raddr = 3'd0; mem_busy = 1'b0;
  endtask

  task automatic set_raw(input logic [2:0] wa, input logic [2:0] ra);
    ex_we = 1'b1; ex_waddr = wa; id_rvalid = 1'b1; id_raddr = ra;
  endtask

  initial begin
`ifdef HAZ_PERF_EN
    perf_clr = 1'b0;
`endif
    idle();
    rst_n = 1'b0;
    tick(); tick();
    check("reset", C_NONE, 2'b00);
    rst_n = 1'b1;

    // Unconditional jump: two kill cycles, no PC stall
    ex_opcode = 8'h03;              check("jmp_c0", C_KILL, 2'b00);
    tick(); ex_opcode = 8'h00;      check("jmp_c1", C_KILL, 2'b10);
    tick();                         check("jmp_end", C_NONE, 2'b00);

    // Conditional JCA not taken then taken
    ex_opcode = 8'h2D; ex_flag = 1'b0; check("jca_nt", C_NONE, 2'b00);
    tick(); ex_flag = 1'b1;            check("jca_t0", C_KILL, 2'b00);
    tick(); idle();                    check("jca_t1", C_KILL, 2'b10);
    tick();                            check("jca_end", C_NONE, 2'b00);

    // Decode boundaries: 0x02 unconditional range edge, 0x08 cond, 0x50 not a transfer
    ex_opcode = 8'h02; ex_flag = 1'b1; check("op02", C_NONE, 2'b00);
    ex_opcode = 8'h50;                 check("op50", C_NONE, 2'b00);
    ex_opcode = 8'h08;                 check("op08", C_KILL, 2'b00);
    tick(); idle();                    check("op08_c1", C_KILL, 2'b10);
    tick();

    // RAW hit: one stall cycle; miss: none
    set_raw(3'd3, 3'd3);            check("raw_hit", C_RAW, 2'b00);
    tick(); id_rvalid = 1'b0;       check("raw_done", C_NONE, 2'b00);
    set_raw(3'd3, 3'd4);            check("raw_miss", C_NONE, 2'b00);
    tick(); idle();

    // mem_busy beats TT; TT flushes after release
    mem_busy = 1'b1; ex_opcode = 8'h06; check("pri_c0", C_HOLD, 2'b00);
    tick();                             check("pri_memw", C_HOLD, 2'b01);
    tick(); mem_busy = 1'b0;            check("pri_rel", C_NONE, 2'b01);
    tick();                             check("pri_tt", C_KILL, 2'b00);
    tick(); ex_opcode = 8'h00;          check("pri_fl", C_KILL, 2'b10);
    tick();                             check("pri_end", C_NONE, 2'b00);

    // Reset mid-FLUSH
    ex_opcode = 8'h04;              check("rstf_c0", C_KILL, 2'b00);
    tick(); ex_opcode = 8'h00;      check("rstf_fl", C_KILL, 2'b10);
    rst_n = 1'b0;
    tick(); rst_n = 1'b1;           check("rstf_after", C_NONE, 2'b00);

    // mem_busy in FLUSH freezes the count, kills stay up
    ex_opcode = 8'h03;
    tick(); ex_opcode = 8'h00; mem_busy = 1'b1; check("flm_c1", C_HK, 2'b10);
    tick();                                   check("flm_frz", C_HK, 2'b10);
    mem_busy = 1'b0;                          check("flm_rel", C_KILL, 2'b10);
    tick();                                   check("flm_end", C_NONE, 2'b00);

    // TT held through FLUSH is ignored there; FLUSH still ends after 2 cycles
    ex_opcode = 8'h05;
    tick();                         check("ttign_fl", C_KILL, 2'b10);
    tick(); ex_opcode = 8'h00;      check("ttign_end", C_NONE, 2'b00);

    // TT and RAW together: kill, no stall
    ex_opcode = 8'h07; set_raw(3'd1, 3'd1); check("tt_raw", C_KILL, 2'b00);
    tick(); idle();                         check("tt_raw_fl", C_KILL, 2'b10);
    tick();

    // Controller disabled
    en = 1'b0; ex_opcode = 8'h03;   check("dis_c0", C_NONE, 2'b00);
    tick();                         check("dis_c1", C_NONE, 2'b00);
    idle();

`ifdef HAZ_PERF_EN
    perf_clr = 1'b1; tick(); perf_clr = 1'b0;
    for (int i = 0; i < 3; i++) begin
      set_raw(3'd2, 3'd2); tick(); idle(); tick();
    end
    ex_opcode = 8'h03; tick(); idle(); tick(); tick();
    check_perf("perf_cnt", 2'd3, 2'd1);
    perf_clr = 1'b1; tick(); perf_clr = 1'b0;
    check_perf("perf_clr", 2'd0, 2'd0);
    for (int i = 0; i < 5; i++) begin
      set_raw(3'd6, 3'd6); tick();
    end
    idle(); tick();
    check_perf("perf_sat", 2'd3, 2'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end
endmodule
